// File: rtl/scan_key_loader.sv
// scan_key_loader: turns PS/2 set-2 make codes into hex digits, assembles them
// MSB-first into a cipher key and hands the key over a valid/ack handshake.

module scan_to_ascii (
   input  logic [7:0] scan_i,
   output logic [7:0] ascii_o
);

   // Only hex-digit keys are mapped; anything else reads back as 'x'.
   always_comb begin
      case (scan_i)
         8'h45:   ascii_o = 8'h30;
         8'h16:   ascii_o = 8'h31;
         8'h1E:   ascii_o = 8'h32;
         8'h26:   ascii_o = 8'h33;
         8'h25:   ascii_o = 8'h34;
         8'h2E:   ascii_o = 8'h35;
         8'h36:   ascii_o = 8'h36;
         8'h3D:   ascii_o = 8'h37;
         8'h3E:   ascii_o = 8'h38;
         8'h46:   ascii_o = 8'h39;
         8'h1C:   ascii_o = 8'h41;
         8'h32:   ascii_o = 8'h42;
         8'h21:   ascii_o = 8'h43;
         8'h23:   ascii_o = 8'h44;
         8'h24:   ascii_o = 8'h45;
         8'h2B:   ascii_o = 8'h46;
         default: ascii_o = 8'h78;
      endcase
   end

endmodule

module scan_key_loader #(
   parameter int NUM_DIGITS = 16,
   parameter int CNT_W      = 5
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    scan_valid_i,
   input  logic [7:0]              scan_code_i,
   input  logic                    key_ack_i,
   output logic [4*NUM_DIGITS-1:0] key_o,
   output logic                    key_valid_o,
   output logic [CNT_W-1:0]        digit_count_o,
   output logic [7:0]              ascii_out_o,
   output logic                    ascii_valid_o,
   output logic                    err_o
);

   localparam int KEY_W = 4 * NUM_DIGITS;
   localparam logic [7:0] BREAK_CODE = 8'hF0;
   localparam logic [7:0] BKSP_CODE  = 8'h66;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(NUM_DIGITS);

   typedef enum logic [1:0] {
      COLLECT,
      BREAK,
      FULL
   } state_e;

   state_e             state_q, state_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic               key_valid_q, key_valid_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [7:0]         ascii_q, ascii_d;
   logic               ascii_valid_q, ascii_valid_d;
   logic               err_q, err_d;

   logic [7:0]         lookup;
   logic               is_digit;
   logic               is_letter;
   logic               is_hex;
   logic [3:0]         nibble;
   logic [CNT_W-1:0]   count_inc;
   logic               is_break;
   logic               is_bksp;

   scan_to_ascii u_lookup (
      .scan_i  (scan_code_i),
      .ascii_o (lookup)
   );

   // Letters 'A'..'F' have low nibbles 1..6, so adding 9 gives ascii - 8'h37.
   always_comb begin
      is_digit  = (lookup >= 8'h30) && (lookup <= 8'h39);
      is_letter = (lookup >= 8'h41) && (lookup <= 8'h46);
      is_hex    = is_digit || is_letter;
      nibble    = is_letter ? (lookup[3:0] + 4'd9) : lookup[3:0];
      count_inc = count_q + CNT_W'(1);
      is_break  = (scan_code_i == BREAK_CODE);
      is_bksp   = (scan_code_i == BKSP_CODE);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= COLLECT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         COLLECT: begin
            if (scan_valid_i) begin
               if (is_break) begin
                  state_d = BREAK;
               end else if (!is_bksp && is_hex && (count_inc == FULL_COUNT)) begin
                  state_d = FULL;
               end
            end
         end
         BREAK: begin
            if (scan_valid_i && !is_break) begin
               state_d = COLLECT;
            end
         end
         FULL: begin
            if (key_ack_i) begin
               state_d = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   // Next values for the registered outputs; ack in FULL wins over any byte.
   always_comb begin
      key_d         = key_q;
      key_valid_d   = key_valid_q;
      count_d       = count_q;
      ascii_d       = ascii_q;
      ascii_valid_d = 1'b0;
      err_d         = 1'b0;
      case (state_q)
         COLLECT: begin
            if (scan_valid_i && !is_break) begin
               if (is_bksp) begin
                  if (count_q != '0) begin
                     key_d   = key_q >> 4;
                     count_d = count_q - CNT_W'(1);
                  end
               end else if (is_hex) begin
                  key_d         = {key_q[KEY_W-5:0], nibble};
                  count_d       = count_inc;
                  ascii_d       = lookup;
                  ascii_valid_d = 1'b1;
                  if (count_inc == FULL_COUNT) begin
                     key_valid_d = 1'b1;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         FULL: begin
            if (key_ack_i) begin
               key_valid_d = 1'b0;
               count_d     = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         key_q         <= '0;
         key_valid_q   <= 1'b0;
         count_q       <= '0;
         ascii_q       <= 8'h00;
         ascii_valid_q <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         key_q         <= key_d;
         key_valid_q   <= key_valid_d;
         count_q       <= count_d;
         ascii_q       <= ascii_d;
         ascii_valid_q <= ascii_valid_d;
         err_q         <= err_d;
      end
   end

   assign key_o         = key_q;
   assign key_valid_o   = key_valid_q;
   assign digit_count_o = count_q;
   assign ascii_out_o   = ascii_q;
   assign ascii_valid_o = ascii_valid_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_scan_key_loader.sv
// tb_scan_key_loader: directed vector table for the key-entry corner cases,
// then random byte streams checked against a digit-level reference model.

module tb_scan_key_loader;

   localparam int N  = 4;
   localparam int CW = 3;
   localparam int KW = 4 * N;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          scan_valid = 1'b0;
   logic [7:0]    scan_code = 8'h00;
   logic          key_ack = 1'b0;
   logic [KW-1:0] key;
   logic          key_valid;
   logic [CW-1:0] digit_count;
   logic [7:0]    ascii_out;
   logic          ascii_valid;
   logic          err;

   int testsRun = 0;
   int testsFailed = 0;

   scan_key_loader #(.NUM_DIGITS(N), .CNT_W(CW)) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .scan_valid_i  (scan_valid),
      .scan_code_i   (scan_code),
      .key_ack_i     (key_ack),
      .key_o         (key),
      .key_valid_o   (key_valid),
      .digit_count_o (digit_count),
      .ascii_out_o   (ascii_out),
      .ascii_valid_o (ascii_valid),
      .err_o         (err)
   );

   always #5 clk = ~clk;

   // Hex value i is typed with hexCodes[i].
   logic [7:0] hexCodes [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                 8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

   int         mKey;
   int         mCount;
   bit         mBreak;
   logic [7:0] mAsc;
   bit         mAv;
   bit         mErr;

   typedef struct {
      logic          rst;
      logic          v;
      logic [7:0]    code;
      logic          ack;
      logic [KW-1:0] key;
      logic          kv;
      logic [CW-1:0] cnt;
      logic [7:0]    asc;
      logic          av;
      logic          er;
      string         name;
   } vec_t;

   vec_t vecs[$];

   function automatic int hexIndex(input logic [7:0] c);
      for (int i = 0; i < 16; i++) begin
         if (hexCodes[i] == c) return i;
      end
      return -1;
   endfunction

   task automatic addVec(input string name, input logic rst, input logic v, input logic [7:0] code,
                         input logic ack, input logic [KW-1:0] k, input logic kv,
                         input logic [CW-1:0] cnt, input logic [7:0] asc, input logic av,
                         input logic er);
      vec_t t;
      t.name = name; t.rst = rst; t.v = v; t.code = code; t.ack = ack;
      t.key = k; t.kv = kv; t.cnt = cnt; t.asc = asc; t.av = av; t.er = er;
      vecs.push_back(t);
   endtask

   // One clock cycle: inputs driven at the falling edge, outputs settle 1 after rising edge.
   task automatic applyStimulus(input logic rst, input logic v, input logic [7:0] c, input logic a);
      @(negedge clk);
      reset = rst;
      scan_valid = v;
      scan_code = c;
      key_ack = a;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [KW-1:0] eKey, input logic eKv,
                              input logic [CW-1:0] eCnt, input logic [7:0] eAsc,
                              input logic eAv, input logic eErr);
      testsRun++;
      if (key !== eKey || key_valid !== eKv || digit_count !== eCnt ||
          ascii_out !== eAsc || ascii_valid !== eAv || err !== eErr) begin
         testsFailed++;
         $display("[TB] FAIL %s: got key=%h kv=%b cnt=%0d ascii=%h av=%b err=%b, want key=%h kv=%b cnt=%0d ascii=%h av=%b err=%b",
                  name, key, key_valid, digit_count, ascii_out, ascii_valid, err,
                  eKey, eKv, eCnt, eAsc, eAv, eErr);
      end
   endtask

   // Reference model: key as a number, full simply means N digits are held.
   task automatic modelStep(input logic rst, input logic v, input logic [7:0] c, input logic a);
      int idx;
      mAv = 0;
      mErr = 0;
      if (rst) begin
         mKey = 0; mCount = 0; mBreak = 0; mAsc = 8'h00;
      end else if (mCount == N) begin
         if (a) mCount = 0;
      end else if (v) begin
         if (mBreak) begin
            mBreak = (c == 8'hF0);
         end else if (c == 8'hF0) begin
            mBreak = 1;
         end else if (c == 8'h66) begin
            if (mCount > 0) begin
               mKey = mKey / 16;
               mCount = mCount - 1;
            end
         end else begin
            idx = hexIndex(c);
            if (idx >= 0) begin
               mKey = (mKey * 16 + idx) % (1 << KW);
               mCount = mCount + 1;
               mAsc = (idx < 10) ? 8'(48 + idx) : 8'(55 + idx);
               mAv = 1;
            end else begin
               mErr = 1;
            end
         end
      end
   endtask

   task automatic checkModel(input string name);
      checkOutput(name, KW'(mKey), (mCount == N), CW'(mCount), mAsc, mAv, mErr);
   endtask

   initial begin
      logic       rv, rvalid, rack;
      logic [7:0] rcode;
      int         pick;

      addVec("reset",      1, 0, 8'h00, 0, 16'h0000, 0, 0, 8'h00, 0, 0);
      addVec("digit1",     0, 1, 8'h16, 0, 16'h0001, 0, 1, 8'h31, 1, 0);
      addVec("idle1",      0, 0, 8'h00, 0, 16'h0001, 0, 1, 8'h31, 0, 0);
      addVec("digit2",     0, 1, 8'h1E, 0, 16'h0012, 0, 2, 8'h32, 1, 0);
      addVec("digit3",     0, 1, 8'h26, 0, 16'h0123, 0, 3, 8'h33, 1, 0);
      addVec("digit4Full", 0, 1, 8'h25, 0, 16'h1234, 1, 4, 8'h34, 1, 0);
      addVec("fullIdle",   0, 0, 8'h00, 0, 16'h1234, 1, 4, 8'h34, 0, 0);
      addVec("full46Drop", 0, 1, 8'h46, 0, 16'h1234, 1, 4, 8'h34, 0, 0);
      addVec("fullF0Drop", 0, 1, 8'hF0, 0, 16'h1234, 1, 4, 8'h34, 0, 0);
      addVec("fullAckWin", 0, 1, 8'h46, 1, 16'h1234, 0, 0, 8'h34, 0, 0);
      addVec("after2E",    0, 1, 8'h2E, 0, 16'h2345, 0, 1, 8'h35, 1, 0);
      addVec("reset2",     1, 0, 8'h00, 0, 16'h0000, 0, 0, 8'h00, 0, 0);
      addVec("makeA",      0, 1, 8'h1C, 0, 16'h000A, 0, 1, 8'h41, 1, 0);
      addVec("breakF0",    0, 1, 8'hF0, 0, 16'h000A, 0, 1, 8'h41, 0, 0);
      addVec("breakA",     0, 1, 8'h1C, 0, 16'h000A, 0, 1, 8'h41, 0, 0);
      addVec("makeB",      0, 1, 8'h32, 0, 16'h00AB, 0, 2, 8'h42, 1, 0);
      addVec("reset3",     1, 0, 8'h00, 0, 16'h0000, 0, 0, 8'h00, 0, 0);
      addVec("dblF0a",     0, 1, 8'hF0, 0, 16'h0000, 0, 0, 8'h00, 0, 0);
      addVec("dblF0b",     0, 1, 8'hF0, 0, 16'h0000, 0, 0, 8'h00, 0, 0);
      addVec("release45",  0, 1, 8'h45, 0, 16'h0000, 0, 0, 8'h00, 0, 0);
      addVec("make45",     0, 1, 8'h45, 0, 16'h0000, 0, 1, 8'h30, 1, 0);
      addVec("errQ",       0, 1, 8'h15, 0, 16'h0000, 0, 1, 8'h30, 0, 1);
      addVec("errOnce",    0, 0, 8'h00, 0, 16'h0000, 0, 1, 8'h30, 0, 0);
      addVec("brkF0",      0, 1, 8'hF0, 0, 16'h0000, 0, 1, 8'h30, 0, 0);
      addVec("brkQnoErr",  0, 1, 8'h15, 0, 16'h0000, 0, 1, 8'h30, 0, 0);
      addVec("reset4",     1, 0, 8'h00, 0, 16'h0000, 0, 0, 8'h00, 0, 0);
      addVec("digitD",     0, 1, 8'h23, 0, 16'h000D, 0, 1, 8'h44, 1, 0);
      addVec("digitE",     0, 1, 8'h24, 0, 16'h00DE, 0, 2, 8'h45, 1, 0);
      addVec("bksp1",      0, 1, 8'h66, 0, 16'h000D, 0, 1, 8'h45, 0, 0);
      addVec("bksp2",      0, 1, 8'h66, 0, 16'h0000, 0, 0, 8'h45, 0, 0);
      addVec("bkspEmpty",  0, 1, 8'h66, 0, 16'h0000, 0, 0, 8'h45, 0, 0);
      addVec("mid1",       0, 1, 8'h16, 0, 16'h0001, 0, 1, 8'h31, 1, 0);
      addVec("mid2",       0, 1, 8'h1E, 0, 16'h0012, 0, 2, 8'h32, 1, 0);
      addVec("ackIgnored", 0, 0, 8'h00, 1, 16'h0012, 0, 2, 8'h32, 0, 0);
      addVec("midReset",   1, 1, 8'h16, 0, 16'h0000, 0, 0, 8'h00, 0, 0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].v, vecs[i].code, vecs[i].ack);
         checkOutput(vecs[i].name, vecs[i].key, vecs[i].kv, vecs[i].cnt,
                     vecs[i].asc, vecs[i].av, vecs[i].er);
      end

      applyStimulus(1, 0, 8'h00, 0);
      modelStep(1, 0, 8'h00, 0);
      checkModel("randReset");

      for (int n = 0; n < 3000; n++) begin
         rv     = ($urandom_range(0, 199) == 0);
         rvalid = ($urandom_range(0, 9) < 6);
         rack   = ($urandom_range(0, 5) == 0);
         pick   = $urandom_range(0, 9);
         if (pick < 5)       rcode = hexCodes[$urandom_range(0, 15)];
         else if (pick == 5) rcode = 8'hF0;
         else if (pick == 6) rcode = 8'h66;
         else                rcode = 8'($urandom_range(0, 255));
         applyStimulus(rv, rvalid, rcode, rack);
         modelStep(rv, rvalid, rcode, rack);
         checkModel("random");
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/scan_key_loader.md
Name: scan_key_loader

Overview:
- Sequencer between the PS/2 byte receiver and the A5/1 key register.
- Consumes one scan-code byte per strobe and converts make codes to ASCII through the existing combinational scan-to-ASCII lookup, instantiated inside this block.
- Discards break sequences, assembles hex digits MSB-first into a key word, and hands the completed key to the cipher core over a valid/ack handshake.

Parameters:
- NUM_DIGITS, 16, hex digits per key; key width is 4*NUM_DIGITS (64 bits for A5/1).
- CNT_W, 5, width of digit_count; must satisfy 2^CNT_W > NUM_DIGITS.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- scan_valid  input  1  one-cycle strobe; scan_code is valid this cycle
- scan_code  input  8  PS/2 set-2 byte
- key_ack  input  1  cipher core has taken key
- key  output  4*NUM_DIGITS  assembled key, MSB digit entered first
- key_valid  output  1  level; high while a complete key is held
- digit_count  output  CNT_W  digits currently stored
- ascii_out  output  8  ASCII of last accepted make code
- ascii_valid  output  1  one-cycle pulse when ascii_out updates
- err  output  1  one-cycle pulse on an unmapped make code

Behaviour:
- Reset is synchronous, active-high, and overrides everything, including mid-key entry:
  - key=0, digit_count=0, key_valid=0, ascii_out=8'h00, ascii_valid=0, err=0, state=COLLECT.
- All outputs are registered. A byte strobed in cycle N takes effect on the outputs in cycle N+1.
- scan_code is ignored when scan_valid=0.
- State COLLECT, on scan_valid:
  - 8'hF0: go to BREAK. No output change.
  - 8'h66 (backspace):
    - If digit_count>0: key <= key>>4, digit_count-1.
    - If digit_count=0: no effect. No err.
  - Otherwise the byte goes through the lookup:
    - Result 8'h78 ('x', unmapped): err pulse. key and count unchanged. ascii_out unchanged, no ascii_valid.
    - Result '0'-'9' (8'h30-8'h39): nibble = ascii[3:0].
    - Result 'A'-'F' (8'h41-8'h46): nibble = ascii - 8'h37.
    - On any valid digit: key <= {key[4*NUM_DIGITS-5:0], nibble}; digit_count+1; ascii_out <= ascii; ascii_valid pulse.
    - If the new count equals NUM_DIGITS: go to FULL, key_valid=1 from the same edge.
- State BREAK, on scan_valid:
  - 8'hF0: stay in BREAK.
  - Any other byte: consumed silently (released key) and return to COLLECT.
  - No err, no ascii_valid in this state.
- State FULL:
  - key_valid held at 1 and key stable.
  - All scan bytes are dropped, including F0. No err, no ascii_valid.
  - key_ack=1: key_valid<=0, digit_count<=0, go to COLLECT. key keeps its value until overwritten by shifting.
- Simultaneous events:
  - key_ack with scan_valid in FULL: ack wins, the byte is dropped.
  - key_ack outside FULL: ignored.
- ascii_valid and err are mutually exclusive and never high for two consecutive cycles from a single strobe.
- digit_count never exceeds NUM_DIGITS and never wraps below 0.

Test Plan:
- NUM_DIGITS=4. Reset, then strobe 16,1E,26,25 (1,2,3,4):
  - ascii_out 31,32,33,34 with one-cycle ascii_valid each.
  - After the 4th strobe, key=16'h1234, key_valid=1, digit_count=4.
- Sequence 1C, F0,1C, 32 (make A, break A, make B):
  - key low byte 8'hAB, digit_count=2.
  - The break sequence causes no ascii_valid.
- Sequence F0,F0,45 then 45:
  - Only the last 45 stores a digit (0). digit_count=1.
- Strobe 8'h15 (Q):
  - err pulse for one cycle. key, digit_count and ascii_out unchanged.
- Sequence 23,24,66 then 66,66:
  - After the first backspace, key=8'h0D, count=1.
  - After the second, count=0. The third has no effect and no err.
- FULL with key=16'h1234:
  - Strobe 46 alone: ignored, key unchanged.
  - Strobe 46 together with key_ack: key_valid=0, count=0, byte dropped.
  - Then strobe 2E: key=16'h2345, count=1.
  - Assert reset mid-entry: all outputs return to reset values on the next edge.
